// File: rtl/block_issue_sequencer_if.sv
// Issue-side handshake, credit-return and enqueue signals of block_issue_sequencer.
// The master drives instructions and credit returns; the slave is the sequencer.
interface block_issue_sequencer_if #(
    parameter int CMD_W = 8,
    parameter int IMM_W = 32
);
    logic             io_valid;
    logic             io_sigs_enq_cmdq;
    logic             io_sigs_enq_ximm1q;
    logic [CMD_W-1:0] io_cmd;
    logic [IMM_W-1:0] io_imm;
    logic             io_cmdq_deq;
    logic             io_ximm1q_deq;
    logic             io_flush;
    logic             io_ready;
    logic             io_replay;
    logic             io_cmdq_enq_valid;
    logic [CMD_W-1:0] io_cmdq_enq_bits;
    logic             io_ximm1q_enq_valid;
    logic [IMM_W-1:0] io_ximm1q_enq_bits;
    logic             io_flush_done;
    logic             io_credit_err;

    modport master (
        output io_valid, io_sigs_enq_cmdq, io_sigs_enq_ximm1q, io_cmd, io_imm,
               io_cmdq_deq, io_ximm1q_deq, io_flush,
        input  io_ready, io_replay, io_cmdq_enq_valid, io_cmdq_enq_bits,
               io_ximm1q_enq_valid, io_ximm1q_enq_bits, io_flush_done, io_credit_err
    );

    modport slave (
        input  io_valid, io_sigs_enq_cmdq, io_sigs_enq_ximm1q, io_cmd, io_imm,
               io_cmdq_deq, io_ximm1q_deq, io_flush,
        output io_ready, io_replay, io_cmdq_enq_valid, io_cmdq_enq_bits,
               io_ximm1q_enq_valid, io_ximm1q_enq_bits, io_flush_done, io_credit_err
    );
endinterface

// File: rtl/block_issue_sequencer.sv
// Credit-based issue sequencer: accepts an instruction only when every queue it needs
// has a credit, enqueues one cycle later, and supports a flush that drains all credits.
module block_issue_sequencer #(
    parameter int CMDQ_DEPTH   = 4,
    parameter int XIMM1Q_DEPTH = 4,
    parameter int CMD_W        = 8,
    parameter int IMM_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    block_issue_sequencer_if.slave io
);
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [3:0] CQ_FULL = 4'(CMDQ_DEPTH);
    localparam logic [3:0] XQ_FULL = 4'(XIMM1Q_DEPTH);

    state_t     state;
    logic [3:0] cq_cr;
    logic [3:0] xq_cr;
    logic       accept;
    logic       cq_dec;
    logic       xq_dec;
    logic       drained;

    always_comb begin
        accept  = io.io_valid && (state == RUN) && !io.io_flush
               && (!io.io_sigs_enq_cmdq   || (cq_cr != '0))
               && (!io.io_sigs_enq_ximm1q || (xq_cr != '0));
        cq_dec  = accept && io.io_sigs_enq_cmdq;
        xq_dec  = accept && io.io_sigs_enq_ximm1q;
        // An enqueue still in the output register has not yet consumed downstream space visibly.
        drained = (state == DRAIN) && (cq_cr == CQ_FULL) && (xq_cr == XQ_FULL)
               && !io.io_cmdq_enq_valid && !io.io_ximm1q_enq_valid;
    end

    assign io.io_ready  = accept;
    assign io.io_replay = io.io_valid && !accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                  <= RUN;
            cq_cr                  <= CQ_FULL;
            xq_cr                  <= XQ_FULL;
            io.io_cmdq_enq_valid   <= 1'b0;
            io.io_ximm1q_enq_valid <= 1'b0;
            io.io_cmdq_enq_bits    <= '0;
            io.io_ximm1q_enq_bits  <= '0;
            io.io_flush_done       <= 1'b0;
            io.io_credit_err       <= 1'b0;
        end else begin
            io.io_cmdq_enq_valid   <= cq_dec;
            io.io_ximm1q_enq_valid <= xq_dec;
            if (accept) begin
                io.io_cmdq_enq_bits   <= io.io_cmd;
                io.io_ximm1q_enq_bits <= io.io_imm;
            end
            io.io_flush_done <= drained;

            case (state)
                RUN:     if (io.io_flush) state <= DRAIN;
                DRAIN:   if (drained)     state <= RUN;
                default: state <= RUN;
            endcase

            // A return at full credits is a protocol error; the counter saturates.
            if (cq_dec && !io.io_cmdq_deq) begin
                cq_cr <= cq_cr - 4'd1;
            end else if (!cq_dec && io.io_cmdq_deq) begin
                if (cq_cr == CQ_FULL) io.io_credit_err <= 1'b1;
                else                  cq_cr <= cq_cr + 4'd1;
            end

            if (xq_dec && !io.io_ximm1q_deq) begin
                xq_cr <= xq_cr - 4'd1;
            end else if (!xq_dec && io.io_ximm1q_deq) begin
                if (xq_cr == XQ_FULL) io.io_credit_err <= 1'b1;
                else                  xq_cr <= xq_cr + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_block_issue_sequencer.sv
// Bench for block_issue_sequencer: directed vector table, hand-written flush/reset
// sequences, then random traffic against a credit-arithmetic reference model.
module tb_block_issue_sequencer;
    localparam int CQD = 4;
    localparam int XQD = 4;
    localparam int CW  = 8;
    localparam int IW  = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    block_issue_sequencer_if #(.CMD_W(CW), .IMM_W(IW)) io ();

    block_issue_sequencer #(
        .CMDQ_DEPTH  (CQD),
        .XIMM1Q_DEPTH(XQD),
        .CMD_W       (CW),
        .IMM_W       (IW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (io)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic ec, input logic ex,
                         input logic [CW-1:0] c, input logic [IW-1:0] im,
                         input logic cd, input logic xd, input logic fl);
        io.io_valid           = v;
        io.io_sigs_enq_cmdq   = ec;
        io.io_sigs_enq_ximm1q = ex;
        io.io_cmd             = c;
        io.io_imm             = im;
        io.io_cmdq_deq        = cd;
        io.io_ximm1q_deq      = xd;
        io.io_flush           = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 with reset released; next edge may accept.
    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk1("rst_cq_valid", io.io_cmdq_enq_valid, 1'b0);
        chk1("rst_xq_valid", io.io_ximm1q_enq_valid, 1'b0);
        chkw("rst_cq_bits", 32'(io.io_cmdq_enq_bits), 32'h0);
        chkw("rst_xq_bits", io.io_ximm1q_enq_bits, 32'h0);
        chk1("rst_flush_done", io.io_flush_done, 1'b0);
        chk1("rst_credit_err", io.io_credit_err, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic          v, ec, ex;
        logic [CW-1:0] c;
        logic [IW-1:0] im;
        logic          cd, xd, fl;
        logic          rdy, rep, cv, xv;
        logic [CW-1:0] cb;
        logic [IW-1:0] xb;
    } vec_t;

    vec_t tbl[13];

    // Reference model: plain credit arithmetic and a draining flag.
    int            m_cq, m_xq;
    bit            m_drain;
    logic          m_cv, m_xv, m_fd, m_err;
    logic [CW-1:0] m_cb;
    logic [IW-1:0] m_xb;

    task automatic model_reset();
        m_cq = CQD; m_xq = XQD; m_drain = 1'b0;
        m_cv = 1'b0; m_xv = 1'b0; m_fd = 1'b0; m_err = 1'b0;
        m_cb = '0; m_xb = '0;
    endtask

    function automatic bit model_accept();
        return io.io_valid && !m_drain && !io.io_flush
            && (!io.io_sigs_enq_cmdq || m_cq > 0)
            && (!io.io_sigs_enq_ximm1q || m_xq > 0);
    endfunction

    task automatic model_step();
        bit a, done;
        int dc, dx, rc, rx;
        a    = model_accept();
        dc   = (a && io.io_sigs_enq_cmdq) ? 1 : 0;
        dx   = (a && io.io_sigs_enq_ximm1q) ? 1 : 0;
        rc   = io.io_cmdq_deq ? 1 : 0;
        rx   = io.io_ximm1q_deq ? 1 : 0;
        done = m_drain && m_cq == CQD && m_xq == XQD && !m_cv && !m_xv;
        if (rc == 1 && dc == 0 && m_cq == CQD) m_err = 1'b1;
        else m_cq = m_cq - dc + rc;
        if (rx == 1 && dx == 0 && m_xq == XQD) m_err = 1'b1;
        else m_xq = m_xq - dx + rx;
        m_cv = (dc == 1);
        m_xv = (dx == 1);
        if (a) begin
            m_cb = io.io_cmd;
            m_xb = io.io_imm;
        end
        m_fd    = done;
        m_drain = m_drain ? !done : io.io_flush;
    endtask

    initial begin
        tbl[0]  = '{1'b1,1'b1,1'b1,8'hA5,32'h12345678,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b1,8'hA5,32'h12345678};
        tbl[1]  = '{1'b1,1'b1,1'b0,8'h01,32'hDEADBEEF,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,8'h01,32'hDEADBEEF};
        tbl[2]  = '{1'b1,1'b1,1'b0,8'h02,32'h00000002,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,8'h02,32'h00000002};
        tbl[3]  = '{1'b1,1'b1,1'b0,8'h03,32'h00000003,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,8'h03,32'h00000003};
        tbl[4]  = '{1'b1,1'b1,1'b0,8'h04,32'h00000004,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,8'h03,32'h00000003};
        tbl[5]  = '{1'b1,1'b1,1'b1,8'h05,32'h00000055,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,8'h03,32'h00000003};
        tbl[6]  = '{1'b0,1'b0,1'b0,8'h06,32'h00000006,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h03,32'h00000003};
        tbl[7]  = '{1'b1,1'b1,1'b0,8'h07,32'h00000007,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,8'h07,32'h00000007};
        tbl[8]  = '{1'b1,1'b1,1'b0,8'h08,32'h00000008,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,8'h08,32'h00000008};
        tbl[9]  = '{1'b1,1'b0,1'b1,8'h09,32'hCAFEF00D,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'h09,32'hCAFEF00D};
        tbl[10] = '{1'b1,1'b0,1'b0,8'h0B,32'h0000000B,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,8'h0B,32'h0000000B};
        tbl[11] = '{1'b0,1'b1,1'b1,8'h0C,32'h0000000C,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h0B,32'h0000000B};
        tbl[12] = '{1'b1,1'b1,1'b0,8'h0D,32'h0000000D,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,8'h0B,32'h0000000B};

        // Directed table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].ex ? tbl[i].ec : tbl[i].ec, tbl[i].ex, tbl[i].c, tbl[i].im,
                  tbl[i].cd, tbl[i].xd, tbl[i].fl);
            @(negedge clk);
            chk1($sformatf("tbl%0d_ready", i), io.io_ready, tbl[i].rdy);
            chk1($sformatf("tbl%0d_replay", i), io.io_replay, tbl[i].rep);
            tick();
            chk1($sformatf("tbl%0d_cq_valid", i), io.io_cmdq_enq_valid, tbl[i].cv);
            chk1($sformatf("tbl%0d_xq_valid", i), io.io_ximm1q_enq_valid, tbl[i].xv);
            chkw($sformatf("tbl%0d_cq_bits", i), 32'(io.io_cmdq_enq_bits), 32'(tbl[i].cb));
            chkw($sformatf("tbl%0d_xq_bits", i), io.io_ximm1q_enq_bits, tbl[i].xb);
            chk1($sformatf("tbl%0d_flush_done", i), io.io_flush_done, 1'b0);
        end

        // No cmdq credit: a both-queue instruction must not consume an ximm1q credit
        do_reset();
        for (int i = 0; i < CQD; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(i), '0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk1("drain_cq_ready", io.io_ready, 1'b1);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 8'h77, 32'h77777777, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk1("both_nocq_ready", io.io_ready, 1'b0);
        chk1("both_nocq_replay", io.io_replay, 1'b1);
        tick();
        chk1("both_nocq_xq_valid", io.io_ximm1q_enq_valid, 1'b0);
        chk1("both_nocq_cq_valid", io.io_cmdq_enq_valid, 1'b0);
        for (int i = 0; i <= XQD; i++) begin
            drive(1'b1, 1'b0, 1'b1, '0, 32'(i), 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk1($sformatf("xq_full_ready%0d", i), io.io_ready, (i < XQD) ? 1'b1 : 1'b0);
            tick();
        end

        // Flush with two outstanding cmdq entries
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(8'h40 + i), '0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk1("pre_flush_ready", io.io_ready, 1'b1);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 8'h50, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk1("flush_cycle_ready", io.io_ready, 1'b0);
        chk1("flush_cycle_replay", io.io_replay, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h51, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk1("drain_replay1", io.io_replay, 1'b1);
        chk1("drain_fd1", io.io_flush_done, 1'b0);
        tick();
        chk1("drain_no_enq", io.io_cmdq_enq_valid, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h52, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk1("drain_replay2", io.io_replay, 1'b1);
        chk1("drain_fd2", io.io_flush_done, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h53, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk1("drain_replay3", io.io_replay, 1'b1);
        chk1("drain_fd3", io.io_flush_done, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h54, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk1("flush_done_pulse", io.io_flush_done, 1'b1);
        chk1("post_drain_ready", io.io_ready, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk1("flush_done_one_cycle", io.io_flush_done, 1'b0);
        chk1("post_drain_enq", io.io_cmdq_enq_valid, 1'b1);
        chkw("post_drain_bits", 32'(io.io_cmdq_enq_bits), 32'h54);
        tick();

        // Sticky credit error, then reset in the middle of a drain
        do_reset();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        chk1("credit_err_set", io.io_credit_err, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk1("credit_err_sticky", io.io_credit_err, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 8'h60, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        #2;
        reset = 1'b0;
        #1;
        chk1("midrst_err", io.io_credit_err, 1'b0);
        chk1("midrst_cq_valid", io.io_cmdq_enq_valid, 1'b0);
        chk1("midrst_fd", io.io_flush_done, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1($sformatf("midrst_no_fd%0d", i), io.io_flush_done, 1'b0);
            tick();
        end
        for (int i = 0; i <= CQD; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(i), '0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk1($sformatf("midrst_full_ready%0d", i), io.io_ready, (i < CQD) ? 1'b1 : 1'b0);
            tick();
        end

        // Random traffic against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            io.io_valid           = ($urandom_range(3) != 0);
            io.io_sigs_enq_cmdq   = $urandom_range(1) == 1;
            io.io_sigs_enq_ximm1q = $urandom_range(1) == 1;
            io.io_cmd             = 8'($urandom());
            io.io_imm             = $urandom();
            io.io_flush           = ($urandom_range(15) == 0);
            io.io_cmdq_deq        = (m_cq < CQD) ? ($urandom_range(1) == 1) : ($urandom_range(63) == 0);
            io.io_ximm1q_deq      = (m_xq < XQD) ? ($urandom_range(1) == 1) : ($urandom_range(63) == 0);
            @(negedge clk);
            chk1("rnd_ready", io.io_ready, model_accept());
            chk1("rnd_replay", io.io_replay, io.io_valid && !model_accept());
            chk1("rnd_cq_valid", io.io_cmdq_enq_valid, m_cv);
            chk1("rnd_xq_valid", io.io_ximm1q_enq_valid, m_xv);
            chkw("rnd_cq_bits", 32'(io.io_cmdq_enq_bits), 32'(m_cb));
            chkw("rnd_xq_bits", io.io_ximm1q_enq_bits, m_xb);
            chk1("rnd_flush_done", io.io_flush_done, m_fd);
            chk1("rnd_credit_err", io.io_credit_err, m_err);
            model_step();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
